muldiv_seq: RTL and testbench
=============================

Name: muldiv_seq

Overview:
- Iterative signed multiply/divide sequencer for the multicycle MIPS datapath.
- Accepts a one-cycle start from the control unit and runs a WIDTH-step radix-2 Booth multiply (MULT) or a restoring divide (DIV).
- Returns a done pulse with HI/LO results and write strobes, or a divide-by-zero exception pulse for the EPC/exception path.
- Owns its own iteration counter and FSM, so the control unit only waits on done/div_zero.

Parameters:
- WIDTH, 32, operand width; results are HI/LO of WIDTH bits each.
- CNT_W, 6, counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- reset_in  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request pulse; sampled only in IDLE.
- op  input  2  2'b00 MULT, 2'b01 DIV, 2'b1x reserved.
- a  input  WIDTH  operand A (multiplicand / dividend), signed.
- b  input  WIDTH  operand B (multiplier / divisor), signed.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; hi/lo valid.
- div_zero  output  1  one-cycle pulse on DIV with b==0.
- hi  output  WIDTH  MULT: product[2W-1:W]; DIV: remainder.
- lo  output  WIDTH  MULT: product[W-1:0]; DIV: quotient.
- hi_w  output  1  HI register write enable; equals done.
- lo_w  output  1  LO register write enable; equals done.

Behaviour:
- Reset: reset_in==0 at a rising edge forces state IDLE and clears the counter. All outputs are 0: busy, done, div_zero, hi, lo, hi_w, lo_w. Reset mid-operation aborts with no done and no write strobes.
- FSM states: IDLE, MULT, DIV, FIN, DZ.
  - IDLE:
    - start=1 and op=00: latch a and b, counter=0, go to MULT.
    - start=1 and op=01 and b!=0: latch operands as magnitudes, record signs, go to DIV.
    - start=1 and op=01 and b==0: go to DZ.
    - op=1x, or start=0: stay in IDLE.
  - MULT: one Booth step per cycle (inspect {Q[0],Q-1}, add/sub M to the upper half, arithmetic shift right of {A,Q,Q-1}). After WIDTH steps go to FIN.
  - DIV: one restoring step per cycle on magnitudes. After WIDTH steps apply signs and go to FIN.
  - FIN: done=hi_w=lo_w=1 for one cycle; hi/lo hold the results; go to IDLE.
  - DZ: div_zero=1 for one cycle, no hi_w/lo_w, hi/lo unchanged; go to IDLE.
- Timing: let start be accepted at edge T0.
  - busy is high from T0 to T(WIDTH+1).
  - done, hi_w and lo_w are high between T(WIDTH+1) and T(WIDTH+2); busy is low in that cycle.
  - Total latency for WIDTH=32 is 33 cycles.
  - div_zero is high between T1 and T2.
- hi/lo hold their last value until the next FIN.
- start while busy is ignored: no queueing, operands are not re-latched.
- start during the FIN or DZ cycle is ignored. The earliest new accept is at the edge after the pulse.
- DIV result rules (MIPS):
  - Quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO=0x80000000, HI=0, no exception.
- MULT is a full 2W-bit signed product; it never overflows.
- Operands are latched at accept, so changes on a/b during busy have no effect.

Optional Feature:
- Macro: MULDIV_FAST_ZERO_EN.
- Defined: in IDLE, if op=00 and (a==0 or b==0), or op=01 and a==0 with b!=0, go directly to FIN. Result is HI=LO=0; done is high between T1 and T2; busy is never asserted.
- Undefined: zero operands take the full WIDTH-step path and the normal latency.

Test Plan:
- MULT a=7, b=0xFFFFFFFD (-3) -> done exactly at T33; HI=0xFFFFFFFF, LO=0xFFFFFFEB; hi_w=lo_w=1 for one cycle.
- MULT a=0x80000000, b=0x80000000 -> HI=0x40000000, LO=0x00000000.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV a=5, b=0 -> div_zero high one cycle at T1; done/hi_w/lo_w stay 0; hi/lo unchanged from the prior op.
- MULT 3*4 with a second start (op=01) at T10 and reset_in=0 at T20 -> second start ignored; after reset all outputs 0 and no done. Rerun 3*4 with no reset -> LO=12, HI=0 at T33. With MULDIV_FAST_ZERO_EN, MULT 0*5 -> done at T1.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative signed multiply/divide sequencer for the multicycle MIPS datapath.
// Runs a WIDTH-step radix-2 Booth multiply (op=00) or restoring divide (op=01)
// and returns HI/LO with one-cycle write strobes, or a divide-by-zero pulse.
// Ports:
//   clk       rising-edge clock
//   reset_in  synchronous active-low reset
//   start     request pulse, sampled only in IDLE
//   op        2'b00 MULT, 2'b01 DIV, 2'b1x reserved (ignored)
//   a, b      signed operands (multiplicand/dividend, multiplier/divisor)
//   busy      operation in progress
//   done      one-cycle result pulse; hi_w/lo_w mirror it
//   div_zero  one-cycle pulse for DIV with b==0
//   hi, lo    MULT product halves / DIV remainder and quotient
// Optional: define MULDIV_FAST_ZERO_EN to finish zero-operand operations in one cycle.
module muldiv_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_in,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             hi_w,
    output logic             lo_w
);
    typedef enum logic [2:0] {S_IDLE, S_MULT, S_DIV, S_FIN, S_DZ} state_t;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH);

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH:0]   r_acc;
    logic [WIDTH-1:0] r_q, r_m, r_hi, r_lo;
    logic             r_q1, r_sa, r_sb, r_hold;
    logic             w_fz;
    logic [WIDTH:0]   w_mext, w_booth, w_shift, w_trial;
    logic [WIDTH-1:0] w_a_mag, w_b_mag, w_quo, w_rem;

`ifdef MULDIV_FAST_ZERO_EN
    assign w_fz = (op == 2'b00 && (a == '0 || b == '0)) || (op == 2'b01 && a == '0 && b != '0);
`else
    assign w_fz = 1'b0;
`endif

    // Accumulator is one bit wider than the operands so that subtracting the
    // most negative multiplicand cannot overflow.
    assign w_mext  = {r_m[WIDTH-1], r_m};
    assign w_booth = (r_q[0] && !r_q1) ? r_acc - w_mext :
                     (!r_q[0] && r_q1) ? r_acc + w_mext : r_acc;
    // Restoring divide: shift next dividend bit into remainder, try subtract.
    assign w_shift = {r_acc[WIDTH-1:0], r_q[WIDTH-1]};
    assign w_trial = w_shift - {1'b0, r_m};
    assign w_a_mag = a[WIDTH-1] ? -a : a;
    assign w_b_mag = b[WIDTH-1] ? -b : b;
    // Quotient truncates toward zero; remainder follows the dividend sign.
    assign w_quo   = (r_sa ^ r_sb) ? -r_q : r_q;
    assign w_rem   = r_sa ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!reset_in)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && op == 2'b00)
                    w_next = w_fz ? S_FIN : S_MULT;
                else if (start && op == 2'b01)
                    w_next = (b == '0) ? S_DZ : (w_fz ? S_FIN : S_DIV);
            end
            S_MULT, S_DIV: w_next = (r_cnt == LAST) ? S_FIN : r_state;
            default:       w_next = r_hold ? r_state : S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (r_state == S_MULT) || (r_state == S_DIV);
        done     = (r_state == S_FIN) && !r_hold;
        div_zero = (r_state == S_DZ) && !r_hold;
        hi_w     = done;
        lo_w     = done;
        hi       = r_hi;
        lo       = r_lo;
    end

    // Pulses entered straight from IDLE (div-by-zero, fast zero) spend one
    // hold cycle first so they line up one edge after the accept.
    always_ff @(posedge clk) begin
        if (!reset_in) begin
            r_cnt  <= '0;
            r_acc  <= '0;
            r_q    <= '0;
            r_q1   <= 1'b0;
            r_m    <= '0;
            r_sa   <= 1'b0;
            r_sb   <= 1'b0;
            r_hold <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_acc  <= '0;
                    r_q1   <= 1'b0;
                    r_hold <= (w_next == S_FIN) || (w_next == S_DZ);
                    if (w_next == S_MULT) begin
                        r_m <= a;
                        r_q <= b;
                    end else if (w_next == S_DIV) begin
                        r_q  <= w_a_mag;
                        r_m  <= w_b_mag;
                        r_sa <= a[WIDTH-1];
                        r_sb <= b[WIDTH-1];
                    end
                end
                S_MULT: begin
                    if (r_cnt == LAST) begin
                        r_hi <= r_acc[WIDTH-1:0];
                        r_lo <= r_q;
                    end else begin
                        r_acc <= {w_booth[WIDTH], w_booth[WIDTH:1]};
                        r_q   <= {w_booth[0], r_q[WIDTH-1:1]};
                        r_q1  <= r_q[0];
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_DIV: begin
                    if (r_cnt == LAST) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_acc <= w_trial[WIDTH] ? w_shift : w_trial;
                        r_q   <= {r_q[WIDTH-2:0], !w_trial[WIDTH]};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_hold <= 1'b0;
                    if (r_state == S_FIN && r_hold) begin
                        r_hi <= '0;
                        r_lo <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven and scoreboard checks for muldiv_seq.
module tb_muldiv_seq;
    logic        clk, reset_in, start;
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        busy, done, div_zero, hi_w, lo_w;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a, b, hi, lo;
        bit          dz;
    } vec_t;

    typedef struct {
        logic [31:0] hi, lo;
        bit          dz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[14];
    int          checks = 0, errors = 0, cyc = 0, t0 = 0;
    logic [31:0] last_hi = 0, last_lo = 0;

    muldiv_seq dut (
        .clk(clk), .reset_in(reset_in), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo),
        .hi_w(hi_w), .lo_w(lo_w)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_idle_zero(input string nm);
        check({nm, " busy"}, busy, 0);
        check({nm, " done"}, done, 0);
        check({nm, " div_zero"}, div_zero, 0);
        check({nm, " hi"}, hi, 0);
        check({nm, " lo"}, lo, 0);
        check({nm, " hi_w"}, hi_w, 0);
        check({nm, " lo_w"}, lo_w, 0);
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] eh, input logic [31:0] el, input bit edz);
        exp_t e;
        bit fz;
        fz = 0;
`ifdef MULDIV_FAST_ZERO_EN
        fz = (o == 2'b00 && (x == 0 || y == 0)) || (o == 2'b01 && x == 0 && y != 0);
`endif
        e.dz  = edz;
        e.hi  = edz ? last_hi : eh;
        e.lo  = edz ? last_lo : el;
        e.lat = (edz || fz) ? 1 : 33;
        sb.push_back(e);
        @(negedge clk);
        op = o; a = x; b = y; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        t0 = cyc;
        check("busy_at_accept", busy, e.lat == 33);
        a = ~x;
        b = ~y;
    endtask

    task automatic collect(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            check({nm, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = sb.pop_front();
        while (!(done || div_zero) && (cyc - t0) < 100) begin
            @(posedge clk);
            #1;
        end
        check({nm, " latency"}, cyc - t0, e.lat);
        check({nm, " done"}, done, !e.dz);
        check({nm, " div_zero"}, div_zero, e.dz);
        check({nm, " hi_w"}, hi_w, !e.dz);
        check({nm, " lo_w"}, lo_w, !e.dz);
        check({nm, " busy_in_pulse"}, busy, 0);
        check({nm, " hi"}, hi, e.hi);
        check({nm, " lo"}, lo, e.lo);
        if (!e.dz) begin
            last_hi = e.hi;
            last_lo = e.lo;
        end
        op = 2'b00; a = 1; b = 1; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check({nm, " pulse_end_done"}, done, 0);
        check({nm, " pulse_end_div_zero"}, div_zero, 0);
        check({nm, " start_in_pulse_ignored"}, busy, 0);
    endtask

    initial begin
        logic [1:0]  o;
        logic [31:0] x, y, eh, el;
        longint      sx, sy, p, q, r;
        int          n_pulse;
        reset_in = 0; start = 0; op = 0; a = 0; b = 0;

        tbl[0]  = '{2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0};
        tbl[1]  = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        tbl[2]  = '{2'b01, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        tbl[3]  = '{2'b01, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        tbl[4]  = '{2'b01, 32'd5,        32'd0,        32'h0,        32'h0,        1'b1};
        tbl[5]  = '{2'b00, 32'd3,        32'd4,        32'h0,        32'd12,       1'b0};
        tbl[6]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'd1,        1'b0};
        tbl[7]  = '{2'b01, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        tbl[8]  = '{2'b01, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0};
        tbl[9]  = '{2'b01, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'd14,       1'b0};
        tbl[10] = '{2'b00, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 1'b0};
        tbl[11] = '{2'b00, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 1'b0};
        tbl[12] = '{2'b00, 32'd0,        32'd5,        32'h0,        32'h0,        1'b0};
        tbl[13] = '{2'b01, 32'd0,        32'd9,        32'h0,        32'h0,        1'b0};

        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("reset");
        @(negedge clk);
        reset_in = 1;

        for (int i = 0; i < 14; i++) begin
            launch(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].dz);
            collect($sformatf("vec%0d", i));
        end

        for (int i = 0; i < 8; i++) begin
            o = 2'(i % 2);
            x = $urandom;
            y = (i >= 4) ? 32'($urandom_range(1, 1000)) : $urandom;
            if (o == 2'b01 && y == 0) y = 1;
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p = sx * sy;
            q = (o == 2'b01) ? sx / sy : 0;
            r = (o == 2'b01) ? sx % sy : 0;
            eh = (o == 2'b00) ? p[63:32] : r[31:0];
            el = (o == 2'b00) ? p[31:0] : q[31:0];
            launch(o, x, y, eh, el, 0);
            collect($sformatf("rand%0d", i));
        end

        launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'b01; a = 100; b = 7; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check("restart_while_busy busy", busy, 1);
        collect("restart_while_busy");

        @(negedge clk);
        op = 2'b10; a = 3; b = 4; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check("reserved_op busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("reserved_op done", done, 0);

        @(negedge clk);
        op = 2'b00; a = 3; b = 4; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        op = 2'b01; a = 100; b = 7; start = 1;
        @(posedge clk);
        #1;
        start = 0;
        check("abort_pre busy", busy, 1);
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_in = 0;
        @(posedge clk);
        #1;
        check_idle_zero("abort_reset");
        @(negedge clk);
        reset_in = 1;
        last_hi = 0;
        last_lo = 0;
        n_pulse = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || div_zero || hi_w || lo_w || busy) n_pulse++;
        end
        check("abort_no_activity", n_pulse, 0);

        launch(2'b00, 32'd3, 32'd4, 32'd0, 32'd12, 0);
        collect("rerun_3x4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
